// File: rtl/cond_pkg.sv
// Shared types and defaults for the board-input conditioner.
package cond_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_STABLE_CNT  = 50000;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by a counter debouncer.
// A new level is accepted only after holding for STABLE_CNT consecutive cycles.
module debounce_bit
  import cond_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_raw,
  output logic q,
  output logic pending
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   q_d;

  assign s       = sync_q[SYNC_STAGES-1];
  assign pending = (state == ST_CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      state  <= ST_STABLE;
      cnt    <= '0;
      q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
      state  <= state_d;
      cnt    <= cnt_d;
      q      <= q_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    q_d     = q;
    case (state)
      ST_STABLE: if (s != q) state_d = ST_CHECK;
      ST_CHECK: begin
        if (s == q) begin
          // glitch rejected: drop the pending change
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          q_d     = s;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the GO button, data and opcode switches per bit.
// Optional GO_PULSE_EN adds a one-cycle go_pulse on each go rising edge.
module input_conditioner
  import cond_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int OP_W        = 3,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go_raw,
  input  logic [DATA_W-1:0] data_raw,
  input  logic [OP_W-1:0]   opcode_raw,
  output logic              go,
  output logic [DATA_W-1:0] data,
  output logic [OP_W-1:0]   opcode,
  output logic              busy
`ifdef GO_PULSE_EN
  ,
  output logic              go_pulse
`endif
);

  localparam int NUM_BITS = 1 + DATA_W + OP_W;

  // bit 0 = go, then data, then opcode
  logic [NUM_BITS-1:0] raw_all, q_all, pend_all;

  assign raw_all = {opcode_raw, data_raw, go_raw};

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .d_raw  (raw_all[i]),
      .q      (q_all[i]),
      .pending(pend_all[i])
    );
  end

  assign go     = q_all[0];
  assign data   = q_all[DATA_W:1];
  assign opcode = q_all[NUM_BITS-1:DATA_W+1];
  assign busy   = |pend_all;

`ifdef GO_PULSE_EN
  logic go_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) go_prev <= 1'b0;
    else          go_prev <= go;
  end

  assign go_pulse = go & ~go_prev;
`endif

endmodule
